// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the pwm_capture block: register group codes and the
// per-channel measurement FSM encoding.
package pwm_capture_pkg;

   localparam logic [3:0] PWMCAP_PERIOD = 4'h0;
   localparam logic [3:0] PWMCAP_HIGH   = 4'h1;
   localparam logic [3:0] PWMCAP_CTRL   = 4'h2;
   localparam logic [3:0] PWMCAP_STATUS = 4'h3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      MEAS = 2'd2
   } pwmcap_state_e;

endpackage

// File: rtl/pwm_capture_chan.sv
// One capture channel: input synchronizer, optional glitch filter
// (PWM_CAPTURE_FILTER_EN), measurement FSM, saturating counters, capture regs.
//
// state | meaning
// IDLE  | channel disabled, counters held at 0
// ARM   | enabled, waiting for the first rising edge
// MEAS  | counting between rising edges, capturing on each rise
module pwm_capture_chan
   import pwm_capture_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             i_cap,
   input  logic             i_en,
   output logic [CNT_W-1:0] o_period,
   output logic [CNT_W-1:0] o_high,
   output logic             o_cap_stb,
   output logic             o_ovf_stb
);

   localparam logic [CNT_W-1:0] CNT_MAX    = '1;
   localparam logic [CNT_W-1:0] CNT_MAX_M1 = CNT_MAX - {{(CNT_W-1){1'b0}}, 1'b1};

   logic             r_sync1;
   logic             r_sync2;
   logic             r_prev;
   logic             w_level;
   logic             w_rise;
   logic             w_meas;
   pwmcap_state_e    r_state;
   logic [CNT_W-1:0] r_pcnt;
   logic [CNT_W-1:0] r_hcnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
      end else begin
         r_sync1 <= i_cap;
         r_sync2 <= r_sync1;
         r_prev  <= w_level;
      end
   end

`ifdef PWM_CAPTURE_FILTER_EN
   logic r_h0;
   logic r_h1;
   logic r_filt;
   logic w_stable;

   // Level follows the input only once three consecutive samples agree.
   assign w_stable = (r_sync2 == r_h0) && (r_h0 == r_h1);
   assign w_level  = w_stable ? r_sync2 : r_filt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_h0   <= 1'b0;
         r_h1   <= 1'b0;
         r_filt <= 1'b0;
      end else begin
         r_h0   <= r_sync2;
         r_h1   <= r_h0;
         r_filt <= w_level;
      end
   end
`else
   assign w_level = r_sync2;
`endif

   assign w_rise = w_level & ~r_prev;
   assign w_meas = i_en && (r_state == MEAS);

   // Strobes are decoded in the capture cycle so STATUS sets line up with the
   // capture registers and can be compared against a same-cycle W1C write.
   assign o_cap_stb = w_meas & w_rise;
   assign o_ovf_stb = w_meas & ~w_rise &
                      ((r_pcnt == CNT_MAX_M1) || (w_level && (r_hcnt == CNT_MAX_M1)));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state  <= IDLE;
         r_pcnt   <= '0;
         r_hcnt   <= '0;
         o_period <= '0;
         o_high   <= '0;
      end else if (!i_en) begin
         r_state <= IDLE;
         r_pcnt  <= '0;
         r_hcnt  <= '0;
      end else begin
         case (r_state)
            IDLE: r_state <= ARM;
            ARM: begin
               if (w_rise) begin
                  r_state <= MEAS;
                  r_pcnt  <= {{(CNT_W-1){1'b0}}, 1'b1};
                  r_hcnt  <= {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            MEAS: begin
               if (w_rise) begin
                  o_period <= r_pcnt;
                  o_high   <= r_hcnt;
                  r_pcnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
                  r_hcnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
               end else begin
                  if (r_pcnt != CNT_MAX) r_pcnt <= r_pcnt + 1'b1;
                  if (w_level && (r_hcnt != CNT_MAX)) r_hcnt <= r_hcnt + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/pwm_capture.sv
// PWM input-capture unit: register decode, CTRL/STATUS, read mux and irq.
// Build option PWM_CAPTURE_FILTER_EN adds a 3-sample glitch filter per channel.
module pwm_capture
   import pwm_capture_pkg::*;
#(
   parameter int channel = 4,
   parameter int CNT_W   = 32
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [31:0]        data_i,
   input  logic [31:0]        addr_i,
   input  logic               we_i,
   output logic [31:0]        data_o,
   input  logic [channel-1:0] cap_i,
   output logic               irq_o
);

   logic [7:0]         w_inner;
   logic [3:0]         w_grp;
   logic [3:0]         w_ch;
   logic               w_ch_ok;
   logic               w_wr_ctrl;
   logic               w_wr_stat;
   logic [channel-1:0] w_valid_clr;
   logic [channel-1:0] w_ovf_clr;
   logic [channel-1:0] w_cap_stb;
   logic [channel-1:0] w_ovf_stb;
   logic [CNT_W-1:0]   w_period [channel];
   logic [CNT_W-1:0]   w_high   [channel];
   logic               w_unused;

   logic [channel-1:0] r_en;
   logic [channel-1:0] r_ie;
   logic [channel-1:0] r_valid;
   logic [channel-1:0] r_ovf;

   assign w_inner  = addr_i[23:16];
   assign w_grp    = w_inner[7:4];
   assign w_ch     = w_inner[3:0];
   assign w_ch_ok  = (32'(w_ch) < channel);
   assign w_unused = ^{addr_i[31:24], addr_i[15:0], data_i};

   assign w_wr_ctrl   = we_i && w_ch_ok && (w_grp == PWMCAP_CTRL);
   assign w_wr_stat   = we_i && w_ch_ok && (w_grp == PWMCAP_STATUS);
   assign w_valid_clr = w_wr_stat ? data_i[channel-1:0]  : '0;
   assign w_ovf_clr   = w_wr_stat ? data_i[16 +: channel] : '0;

   generate
      for (genvar g = 0; g < channel; g++) begin : g_chan
         pwm_capture_chan #(
            .CNT_W(CNT_W)
         ) u_chan (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .i_cap     (cap_i[g]),
            .i_en      (r_en[g]),
            .o_period  (w_period[g]),
            .o_high    (w_high[g]),
            .o_cap_stb (w_cap_stb[g]),
            .o_ovf_stb (w_ovf_stb[g])
         );
      end
   endgenerate

   // Hardware sets are OR-ed in after the W1C mask, so a same-cycle set wins.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_en    <= '0;
         r_ie    <= '0;
         r_valid <= '0;
         r_ovf   <= '0;
      end else begin
         if (w_wr_ctrl) begin
            r_en <= data_i[channel-1:0];
            r_ie <= data_i[16 +: channel];
         end
         r_valid <= (r_valid & ~w_valid_clr) | w_cap_stb;
         r_ovf   <= (r_ovf   & ~w_ovf_clr)   | w_ovf_stb;
      end
   end

   assign irq_o = |(r_valid & r_ie);

   always_comb begin
      data_o = '0;
      if (w_ch_ok) begin
         case (w_grp)
            PWMCAP_PERIOD: begin
               for (int k = 0; k < channel; k++) begin
                  if (32'(w_ch) == k) data_o = 32'(w_period[k]);
               end
            end
            PWMCAP_HIGH: begin
               for (int k = 0; k < channel; k++) begin
                  if (32'(w_ch) == k) data_o = 32'(w_high[k]);
               end
            end
            PWMCAP_CTRL: begin
               data_o[channel-1:0]  = r_en;
               data_o[16 +: channel] = r_ie;
            end
            PWMCAP_STATUS: begin
               data_o[channel-1:0]  = r_valid;
               data_o[16 +: channel] = r_ovf;
            end
            default: data_o = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// Randomized bench for pwm_capture: waveforms are recorded per cycle and the
// expected PERIOD/HIGH are derived from rising-edge positions in that record.
module tb_pwm_capture;

   localparam int NCH  = 4;
   localparam int CW   = 8;
   localparam int CMAX = 255;
`ifdef PWM_CAPTURE_FILTER_EN
   localparam int LAT  = 5;
   localparam bit FILT = 1'b1;
`else
   localparam int LAT  = 3;
   localparam bit FILT = 1'b0;
`endif

   logic           clk_i  = 1'b0;
   logic           rst_i  = 1'b1;
   logic [31:0]    data_i = '0;
   logic [31:0]    addr_i = '0;
   logic           we_i   = 1'b0;
   logic [31:0]    data_o;
   logic [NCH-1:0] cap_i  = '0;
   logic           irq_o;

   pwm_capture #(
      .channel(NCH),
      .CNT_W  (CW)
   ) dut (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .data_i (data_i),
      .addr_i (addr_i),
      .we_i   (we_i),
      .data_o (data_o),
      .cap_i  (cap_i),
      .irq_o  (irq_o)
   );

   always #5 clk_i = ~clk_i;

   int             n_vec = 0;
   int             n_err = 0;
   bit             seq[$];
   bit             mq[$];
   int             exp_per [NCH];
   int             exp_hi  [NCH];
   logic [NCH-1:0] exp_valid = '0;
   logic [NCH-1:0] exp_ovf   = '0;
   logic [NCH-1:0] exp_en    = '0;
   logic [NCH-1:0] exp_ie    = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic bus_wr(input logic [7:0] inner, input logic [31:0] d);
      tick();
      addr_i = {8'h00, inner, 16'h0000};
      data_i = d;
      we_i   = 1'b1;
      tick();
      we_i   = 1'b0;
   endtask

   task automatic chk_rd(input string tag, input logic [7:0] inner, input logic [31:0] exp);
      addr_i = {8'h00, inner, 16'h0000};
      #1;
      check(tag, data_o, exp);
   endtask

   task automatic set_ctrl();
      bus_wr(8'h20, {12'h000, exp_ie, 12'h000, exp_en});
   endtask

   task automatic clear_status();
      bus_wr(8'h30, 32'hFFFF_FFFF);
      exp_valid = '0;
      exp_ovf   = '0;
   endtask

   task automatic push(input bit v, input int n);
      repeat (n) seq.push_back(v);
   endtask

   // Plays seq on one channel; optionally issues a STATUS W1C at index wc_idx.
   task automatic run_seq(input int ch, input int wc_idx, input logic [31:0] wc_data);
      for (int i = 0; i < seq.size(); i++) begin
         tick();
         cap_i[ch] = seq[i];
         mq.push_back(seq[i]);
         if (i == wc_idx) begin
            addr_i = 32'h0030_0000;
            data_i = wc_data;
            we_i   = 1'b1;
         end else begin
            we_i = 1'b0;
         end
      end
      seq.delete();
   endtask

   // Expected captures: the last two rising edges of the (optionally filtered)
   // level recorded since enable delimit the most recent measurement window.
   function automatic void update_model(input int ch);
      bit lv[$];
      int rises[$];
      bit lvl;
      int a, b, p, h;
      lvl = 1'b0;
      for (int i = 0; i < mq.size(); i++) begin
         if (FILT) begin
            if (i >= 2 && mq[i] == mq[i-1] && mq[i-1] == mq[i-2]) lvl = mq[i];
            lv.push_back(lvl);
         end else begin
            lv.push_back(mq[i]);
         end
      end
      for (int i = 0; i < lv.size(); i++) begin
         if (lv[i] && (i == 0 || !lv[i-1])) rises.push_back(i);
      end
      if (rises.size() >= 2) begin
         a = rises[rises.size()-1];
         b = rises[rises.size()-2];
         p = a - b;
         h = 0;
         for (int i = b; i < a; i++) h += int'(lv[i]);
         exp_per[ch]   = (p > CMAX) ? CMAX : p;
         exp_hi[ch]    = (h > CMAX) ? CMAX : h;
         exp_valid[ch] = 1'b1;
      end
   endfunction

   task automatic check_chan(input string tag, input int ch);
      chk_rd({tag, "_period"}, 8'(8'h00 + ch), 32'(exp_per[ch]));
      chk_rd({tag, "_high"},   8'(8'h10 + ch), 32'(exp_hi[ch]));
      chk_rd({tag, "_status"}, 8'h30, {12'h000, exp_ovf, 12'h000, exp_valid});
      check({tag, "_irq"}, 32'(irq_o), 32'(|(exp_valid & exp_ie)));
   endtask

   task automatic enable_chan(input int ch, input logic ie);
      exp_en     = '0;
      exp_en[ch] = 1'b1;
      exp_ie     = '0;
      exp_ie[ch] = ie;
      set_ctrl();
      mq.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int ch, hi, lo, np;
      for (int i = 0; i < NCH; i++) begin
         exp_per[i] = 0;
         exp_hi[i]  = 0;
      end

      repeat (3) tick();
      chk_rd("rst_ctrl",   8'h20, 32'h0);
      chk_rd("rst_status", 8'h30, 32'h0);
      chk_rd("rst_period", 8'h00, 32'h0);
      check("rst_irq", 32'(irq_o), 32'h0);
      rst_i = 1'b0;
      tick();

      // Randomized clean waveforms on random channels.
      for (int it = 0; it < 8; it++) begin
         ch = int'($urandom_range(0, NCH-1));
         hi = int'($urandom_range(3, 20));
         lo = int'($urandom_range(3, 20));
         np = int'($urandom_range(1, 3));
         enable_chan(ch, 1'($urandom_range(0, 1)));
         chk_rd("rnd_ctrl", 8'h20, {12'h000, exp_ie, 12'h000, exp_en});
         push(0, 4);
         repeat (np) begin
            push(1, hi);
            push(0, lo);
         end
         push(1, hi);
         push(0, 6);
         run_seq(ch, -1, 32'h0);
         update_model(ch);
         check_chan("rnd", ch);
         exp_en = '0;
         set_ctrl();
         clear_status();
      end

      // ch1 square 4/4 with interrupt enabled, then W1C of valid[1].
      enable_chan(1, 1'b1);
      push(0, 4);
      repeat (2) begin
         push(1, 4);
         push(0, 4);
      end
      push(1, 4);
      push(0, 6);
      run_seq(1, -1, 32'h0);
      update_model(1);
      check_chan("sq", 1);
      check("sq_period_const", 32'(exp_per[1]), 32'd8);
      bus_wr(8'h30, 32'h0000_0002);
      exp_valid[1] = 1'b0;
      chk_rd("sq_w1c_status", 8'h30, {12'h000, exp_ovf, 12'h000, exp_valid});
      check("sq_w1c_irq", 32'(irq_o), 32'h0);
      exp_en = '0;
      set_ctrl();
      clear_status();

      // ch2 held high after one rise: counters saturate at 255.
      enable_chan(2, 1'b0);
      push(0, 4);
      push(1, 400);
      run_seq(2, -1, 32'h0);
      exp_ovf[2] = 1'b1;
      update_model(2);
      chk_rd("sat_status", 8'h30, {12'h000, exp_ovf, 12'h000, exp_valid});
      push(0, 5);
      push(1, 3);
      push(0, 6);
      run_seq(2, -1, 32'h0);
      update_model(2);
      check_chan("sat", 2);
      exp_en = '0;
      set_ctrl();
      clear_status();

      // ch0 disabled mid-period, values retained, re-enable re-arms.
      enable_chan(0, 1'b0);
      push(0, 4);
      repeat (2) begin
         push(1, 4);
         push(0, 5);
      end
      push(1, 4);
      push(0, 2);
      run_seq(0, -1, 32'h0);
      update_model(0);
      exp_en = '0;
      set_ctrl();
      check_chan("dis_hold", 0);
      clear_status();
      enable_chan(0, 1'b0);
      push(0, 4);
      push(1, 3);
      push(0, 2);
      run_seq(0, -1, 32'h0);
      update_model(0);
      check_chan("rearm_one", 0);
      push(0, 1);
      push(1, 3);
      push(0, 6);
      run_seq(0, -1, 32'h0);
      update_model(0);
      check_chan("rearm_two", 0);
      exp_en = '0;
      set_ctrl();
      clear_status();

      // Register map corner cases.
      chk_rd("unmapped_grp", 8'h40, 32'h0);
      chk_rd("unmapped_ch",  8'h05, 32'h0);
      bus_wr(8'h00, 32'hFFFF_FFFF);
      chk_rd("ro_period", 8'h00, 32'(exp_per[0]));
      bus_wr(8'h25, 32'hFFFF_FFFF);
      chk_rd("ctrl_bad_ch", 8'h20, 32'h0);

      // W1C to valid[0] in the exact capture cycle: the set wins.
      enable_chan(0, 1'b0);
      push(0, 4);
      push(1, 4);
      push(0, 4);
      push(1, 4);
      push(0, 6);
      run_seq(0, 12 + LAT - 1, 32'h0000_0001);
      update_model(0);
      check_chan("setwins", 0);
      bus_wr(8'h30, 32'h0000_0001);
      exp_valid[0] = 1'b0;
      chk_rd("late_w1c", 8'h30, {12'h000, exp_ovf, 12'h000, exp_valid});
      exp_en = '0;
      set_ctrl();
      clear_status();

      // 1-cycle glitch in the low phase of ch3.
      enable_chan(3, 1'b0);
      push(0, 4);
      push(1, 5);
      push(0, 4);
      push(1, 1);
      push(0, 5);
      push(1, 5);
      push(0, 8);
      run_seq(3, -1, 32'h0);
      update_model(3);
      check_chan("glitch", 3);
      check("glitch_period_const", 32'(exp_per[3]), FILT ? 32'd15 : 32'd6);
      exp_en = '0;
      set_ctrl();
      clear_status();

      // Asynchronous reset while ch0 is measuring with irq asserted.
      enable_chan(0, 1'b1);
      push(0, 4);
      repeat (2) begin
         push(1, 3);
         push(0, 3);
      end
      push(1, 3);
      push(0, 6);
      run_seq(0, -1, 32'h0);
      update_model(0);
      check_chan("pre_rst", 0);
      @(posedge clk_i);
      #3;
      rst_i = 1'b1;
      cap_i = '0;
      #1;
      check("async_rst_irq", 32'(irq_o), 32'h0);
      chk_rd("async_rst_ctrl",   8'h20, 32'h0);
      chk_rd("async_rst_status", 8'h30, 32'h0);
      chk_rd("async_rst_period", 8'h00, 32'h0);
      chk_rd("async_rst_high",   8'h10, 32'h0);
      repeat (2) tick();
      rst_i = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
